clus_ctrl: RTL and testbench



---
 rtl/clus_ctrl_pkg.sv | 32 +++
 rtl/clus_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_clus_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clus_ctrl_pkg.sv
// Shared types and sizing helpers for the single-cluster convolution-pass sequencer.
package clus_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_WGHT,
        S_LD_IACT,
        S_SP_WGHT,
        S_SP_IACT,
        S_COMPUTE,
        S_WB_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_OUT_HOLD,
        S_DONE
    } state_e;

    // One spare bit above the bits needed for the largest count keeps compares clean.
    function automatic int cnt_width(input int max_count);
        return $clog2(max_count) + 1;
    endfunction

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/clus_ctrl.sv
// Sequencer for one convolution pass: host load into GLBs, spad loads, PE compute,
// psum write-back wait, then a backpressured drain of the psum GLB.
module clus_ctrl
    import clus_ctrl_pkg::*;
#(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int WGHT_COUNT    = 9,
    parameter int IACT_COUNT    = 144,
    parameter int PSUM_COUNT    = 100,
    parameter int WB_CYCLES     = 4,
    parameter int WGHT_BASE     = 0,
    parameter int IACT_BASE     = 0,
    parameter int PSUM_BASE     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_BITWIDTH-1:0] in_data,
    output logic                     write_en_wght,
    output logic                     write_en_iact,
    output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
    output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
    output logic [DATA_BITWIDTH-1:0] w_data_wght,
    output logic [DATA_BITWIDTH-1:0] w_data_iact,
    output logic                     load_spad_ctrl_wght,
    output logic                     load_spad_ctrl_iact,
    input  logic                     load_done_wght,
    input  logic                     load_done_iact,
    output logic                     pe_start,
    input  logic                     write_psum_ctrl,
    output logic                     read_req_psum,
    output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
    input  logic [DATA_BITWIDTH-1:0] r_data_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITWIDTH-1:0] out_data
);

    localparam int CNT_W = cnt_width(max_of4(WGHT_COUNT, IACT_COUNT, PSUM_COUNT, WB_CYCLES));

    localparam logic [CNT_W-1:0] WGHT_LAST = CNT_W'(WGHT_COUNT - 1);
    localparam logic [CNT_W-1:0] IACT_LAST = CNT_W'(IACT_COUNT - 1);
    localparam logic [CNT_W-1:0] PSUM_LAST = CNT_W'(PSUM_COUNT - 1);
    localparam logic [CNT_W-1:0] WB_LAST   = CNT_W'(WB_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     write_en_wght_q, write_en_wght_d;
    logic                     write_en_iact_q, write_en_iact_d;
    logic [ADDR_BITWIDTH-1:0] w_addr_wght_q, w_addr_wght_d;
    logic [ADDR_BITWIDTH-1:0] w_addr_iact_q, w_addr_iact_d;
    logic [DATA_BITWIDTH-1:0] w_data_wght_q, w_data_wght_d;
    logic [DATA_BITWIDTH-1:0] w_data_iact_q, w_data_iact_d;
    logic                     pe_start_q, pe_start_d;
    logic [DATA_BITWIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        write_en_wght_d = 1'b0;
        write_en_iact_d = 1'b0;
        w_addr_wght_d   = w_addr_wght_q;
        w_addr_iact_d   = w_addr_iact_q;
        w_data_wght_d   = w_data_wght_q;
        w_data_iact_d   = w_data_iact_q;
        pe_start_d      = 1'b0;
        out_data_d      = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LD_WGHT;
                    cnt_d   = '0;
                end
            end
            S_LD_WGHT: begin
                if (in_valid) begin
                    write_en_wght_d = 1'b1;
                    w_addr_wght_d   = ADDR_BITWIDTH'(WGHT_BASE) + ADDR_BITWIDTH'(cnt_q);
                    w_data_wght_d   = in_data;
                    if (cnt_q == WGHT_LAST) begin
                        state_d = S_LD_IACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LD_IACT: begin
                if (in_valid) begin
                    write_en_iact_d = 1'b1;
                    w_addr_iact_d   = ADDR_BITWIDTH'(IACT_BASE) + ADDR_BITWIDTH'(cnt_q);
                    w_data_iact_d   = in_data;
                    if (cnt_q == IACT_LAST) begin
                        state_d = S_SP_WGHT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SP_WGHT: begin
                if (load_done_wght) state_d = S_SP_IACT;
            end
            S_SP_IACT: begin
                // Registering the start pulse here makes it land on the first COMPUTE cycle.
                if (load_done_iact) begin
                    state_d    = S_COMPUTE;
                    pe_start_d = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (write_psum_ctrl) begin
                    state_d = S_WB_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WB_WAIT: begin
                if (cnt_q == WB_LAST) begin
                    state_d = S_RD_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                out_data_d = r_data_psum;
                state_d    = S_OUT_HOLD;
            end
            S_OUT_HOLD: begin
                if (out_ready) begin
                    if (cnt_q == PSUM_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RD_ISSUE;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            write_en_wght_q <= 1'b0;
            write_en_iact_q <= 1'b0;
            w_addr_wght_q   <= '0;
            w_addr_iact_q   <= '0;
            w_data_wght_q   <= '0;
            w_data_iact_q   <= '0;
            pe_start_q      <= 1'b0;
            out_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            write_en_wght_q <= write_en_wght_d;
            write_en_iact_q <= write_en_iact_d;
            w_addr_wght_q   <= w_addr_wght_d;
            w_addr_iact_q   <= w_addr_iact_d;
            w_data_wght_q   <= w_data_wght_d;
            w_data_iact_q   <= w_data_iact_d;
            pe_start_q      <= pe_start_d;
            out_data_q      <= out_data_d;
        end
    end

    assign busy                = (state_q != S_IDLE);
    assign done                = (state_q == S_DONE);
    assign in_ready            = (state_q == S_LD_WGHT) || (state_q == S_LD_IACT);
    assign write_en_wght       = write_en_wght_q;
    assign write_en_iact       = write_en_iact_q;
    assign w_addr_wght         = w_addr_wght_q;
    assign w_addr_iact         = w_addr_iact_q;
    assign w_data_wght         = w_data_wght_q;
    assign w_data_iact         = w_data_iact_q;
    assign load_spad_ctrl_wght = (state_q == S_SP_WGHT);
    assign load_spad_ctrl_iact = (state_q == S_SP_IACT);
    assign pe_start            = pe_start_q;
    assign read_req_psum       = (state_q == S_RD_ISSUE);
    // Address is forced to zero outside RD_ISSUE so the read port is quiet when idle.
    assign r_addr_psum         = read_req_psum ? (ADDR_BITWIDTH'(PSUM_BASE) + ADDR_BITWIDTH'(cnt_q))
                                               : '0;
    assign out_valid           = (state_q == S_OUT_HOLD);
    assign out_data            = out_data_q;

endmodule

// File: tb/tb_clus_ctrl.sv
// Randomised self-checking bench for clus_ctrl with a cluster/GLB model and a
// transaction-level reference of the expected write, read and output streams.
module tb_clus_ctrl;

    localparam int DW  = 16;
    localparam int AW  = 10;
    localparam int NW  = 9;
    localparam int NI  = 144;
    localparam int NP  = 100;
    localparam int TOT = NW + NI;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          go = 1'b0;
    logic          busy, done;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          write_en_wght, write_en_iact;
    logic [AW-1:0] w_addr_wght, w_addr_iact;
    logic [DW-1:0] w_data_wght, w_data_iact;
    logic          load_spad_ctrl_wght, load_spad_ctrl_iact;
    logic          load_done_wght, load_done_iact;
    logic          pe_start;
    logic          write_psum_ctrl;
    logic          read_req_psum;
    logic [AW-1:0] r_addr_psum;
    logic [DW-1:0] r_data_psum;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    clus_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .go                  (go),
        .busy                (busy),
        .done                (done),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .write_en_wght       (write_en_wght),
        .write_en_iact       (write_en_iact),
        .w_addr_wght         (w_addr_wght),
        .w_addr_iact         (w_addr_iact),
        .w_data_wght         (w_data_wght),
        .w_data_iact         (w_data_iact),
        .load_spad_ctrl_wght (load_spad_ctrl_wght),
        .load_spad_ctrl_iact (load_spad_ctrl_iact),
        .load_done_wght      (load_done_wght),
        .load_done_iact      (load_done_iact),
        .pe_start            (pe_start),
        .write_psum_ctrl     (write_psum_ctrl),
        .read_req_psum       (read_req_psum),
        .r_addr_psum         (r_addr_psum),
        .r_data_psum         (r_data_psum),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data)
    );

    initial forever #5 clk = ~clk;

    // ---------------- cluster / GLB model ----------------
    logic [DW-1:0] psum_mem [0:NP-1];
    int            ldw_cnt = 0, ldi_cnt = 0, comp_t = 0;
    logic          ldw_q = 1'b0, ldi_q = 1'b0, wpc_q = 1'b0, ldw_pre = 1'b0;
    logic [DW-1:0] r_data_q = '0;

    assign load_done_wght  = ldw_pre | ldw_q;
    assign load_done_iact  = ldi_q;
    assign write_psum_ctrl = wpc_q;
    assign r_data_psum     = r_data_q;

    always @(posedge clk) begin
        if (load_spad_ctrl_wght) begin
            ldw_cnt <= ldw_cnt + 1;
            ldw_q   <= (ldw_cnt >= 4);
            wpc_q   <= 1'b0;
        end else begin
            ldw_cnt <= 0;
            ldw_q   <= 1'b0;
        end
        if (load_spad_ctrl_iact) begin
            ldi_cnt <= ldi_cnt + 1;
            ldi_q   <= (ldi_cnt >= 4);
        end else begin
            ldi_cnt <= 0;
            ldi_q   <= 1'b0;
        end
        if (pe_start) begin
            comp_t <= 50;
            wpc_q  <= 1'b0;
        end else if (comp_t > 0) begin
            comp_t <= comp_t - 1;
            if (comp_t == 1) wpc_q <= 1'b1;
        end
        if (read_req_psum)
            r_data_q <= (r_addr_psum < AW'(NP)) ? psum_mem[r_addr_psum] : 16'hDEAD;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word(input int k);
        return (k < NW) ? DW'(k + 1) : DW'(k - NW);
    endfunction

    // stimulus knobs (written by the sequencer, read by the driver)
    int in_mode = 0, out_mode = 0;
    bit stall_en = 0, go_req = 0;

    // reference state
    bit            act = 0, done_exp = 0, pw = 0, pi = 0, comp_seen = 0, first_seen = 0, was_act;
    int            acc = 0, oi = 0, rd = 0, stalls = 0;
    int            pwa = 0, pia = 0;
    logic [DW-1:0] pwd = '0, pid = '0, out5 = '0;
    logic [AW-1:0] first_w_addr = '0;
    int            wr_w = 0, wr_i = 0, n_rd = 0, n_out = 0, pe_cnt = 0, dn_cnt = 0;
    int            busy_cyc = 0, ctrlw_cyc = 0, ctrli_cyc = 0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_ctrl", {busy, done, in_ready, write_en_wght, write_en_iact, load_spad_ctrl_wght,
                                 load_spad_ctrl_iact, pe_start, read_req_psum, out_valid}, '0);
                chk("rst_bus", {w_addr_wght, w_addr_iact, w_data_wght, w_data_iact, r_addr_psum, out_data}, '0);
                act = 0; pw = 0; pi = 0; done_exp = 0;
            end else begin
                chk("busy", busy, act);
                chk("in_ready", in_ready, act && (acc < TOT));
                chk("done", done, done_exp);
                if (done) dn_cnt++;
                if (busy) busy_cyc++;
                chk("we_wght", write_en_wght, pw);
                if (pw && write_en_wght) begin
                    chk("w_addr_wght", w_addr_wght, pwa);
                    chk("w_data_wght", w_data_wght, pwd);
                    if (!first_seen) begin first_seen = 1; first_w_addr = w_addr_wght; end
                    wr_w++;
                end
                chk("we_iact", write_en_iact, pi);
                if (pi && write_en_iact) begin
                    chk("w_addr_iact", w_addr_iact, pia);
                    chk("w_data_iact", w_data_iact, pid);
                    wr_i++;
                end
                if (load_spad_ctrl_wght) begin
                    chk("ctrlw_phase", act && acc == TOT && pe_cnt == 0, 1);
                    ctrlw_cyc++;
                end
                if (load_spad_ctrl_iact) begin
                    chk("ctrli_phase", act && ctrlw_cyc > 0 && pe_cnt == 0, 1);
                    ctrli_cyc++;
                end
                if (pe_start) begin
                    chk("pe_phase", act && acc == TOT && ctrli_cyc > 0 && pe_cnt == 0, 1);
                    pe_cnt++;
                end
                if (act && write_psum_ctrl && pe_cnt > 0) comp_seen = 1;
                if (read_req_psum) begin
                    chk("rd_phase", comp_seen, 1);
                    chk("rd_addr", r_addr_psum, rd);
                    chk("rd_ahead", rd, oi);
                    rd++;
                    n_rd++;
                end
                if (out_valid) begin
                    chk("ov_phase", comp_seen && (rd == oi + 1), 1);
                    chk("out_data", out_data, (oi < NP) ? psum_mem[oi] : 16'hBAD0);
                end
            end

            // drive inputs for the next rising edge
            go = go_req;
            go_req = 0;
            case (in_mode)
                0:       in_valid = 1'b1;
                1:       in_valid = !in_valid;
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = in_valid ? word(acc) : DW'($urandom);
            if (stall_en && oi == 5 && stalls < 7) out_ready = 1'b0;
            else if (out_mode == 0)                out_ready = 1'b1;
            else                                   out_ready = ($urandom_range(0, 3) != 0);

            // advance the reference with what the next edge will see
            if (reset) begin
                was_act = act;
                if (done_exp) act = 0;
                done_exp = 0;
                if (!was_act && go) begin
                    act = 1; acc = 0; oi = 0; rd = 0; stalls = 0; comp_seen = 0; first_seen = 0;
                    wr_w = 0; wr_i = 0; n_rd = 0; n_out = 0; pe_cnt = 0; dn_cnt = 0;
                    busy_cyc = 0; ctrlw_cyc = 0; ctrli_cyc = 0;
                end
                pw = 0; pi = 0;
                if (in_valid && in_ready) begin
                    if (acc < NW) begin pw = 1; pwa = acc;      pwd = word(acc); end
                    else          begin pi = 1; pia = acc - NW; pid = word(acc); end
                    acc++;
                end
                if (out_valid) begin
                    if (out_ready) begin
                        if (oi == 5) out5 = out_data;
                        n_out++;
                        oi++;
                        if (oi == NP) done_exp = 1;
                    end else if (oi == 5) begin
                        stalls++;
                    end
                end
            end
        end
    end

    task automatic run_pass(input string nm, input int im, input int om, input bit st,
                            input bit gic);
        bit started, fin, issued;
        in_mode = im; out_mode = om; stall_en = st;
        started = 0; fin = 0; issued = 0;
        @(posedge clk);
        go_req = 1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            if (act) begin started = 1; break; end
        end
        chk({nm, "_start"}, started, 1);
        for (int c = 0; c < 5000 && started; c++) begin
            @(posedge clk);
            if (gic && pe_cnt > 0 && !issued) begin go_req = 1; issued = 1; end
            if (!act) begin fin = 1; break; end
        end
        chk({nm, "_finish"}, fin, 1);
        chk({nm, "_wr_w"}, wr_w, NW);
        chk({nm, "_wr_i"}, wr_i, NI);
        chk({nm, "_reads"}, n_rd, NP);
        chk({nm, "_outs"}, n_out, NP);
        chk({nm, "_pe"}, pe_cnt, 1);
        chk({nm, "_done"}, dn_cnt, 1);
        chk({nm, "_first_addr"}, first_w_addr, 0);
        $display("pass %s: busy_cycles=%0d spad_wght_cycles=%0d outputs=%0d", nm, busy_cyc, ctrlw_cyc, n_out);
    endtask

    int base_cyc;
    bit hit;

    initial begin : sequencer
        for (int i = 0; i < NP; i++) psum_mem[i] = DW'(i * 37 + 11);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        run_pass("baseline", 0, 0, 0, 0);
        base_cyc = busy_cyc;
        chk("baseline_cycles", busy_cyc, 522);
        chk("baseline_spad_w", ctrlw_cyc, 6);

        run_pass("in_toggle", 1, 0, 0, 0);

        run_pass("out_stall", 0, 0, 1, 0);
        chk("stall_cycles", stalls, 7);
        chk("psum5_value", out5, 16'd196);

        run_pass("go_in_compute", 0, 0, 0, 1);
        chk("go_ignored_cycles", busy_cyc, base_cyc);

        // reset mid-pass at iact word 70
        in_mode = 0; out_mode = 0; stall_en = 0;
        @(posedge clk);
        go_req = 1;
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            if (act && acc == NW + 70) begin hit = 1; break; end
        end
        chk("reach_iact70", hit, 1);
        #1 reset = 1'b0;
        #1;
        chk("rst_now_ctrl", {busy, done, in_ready, write_en_wght, write_en_iact, load_spad_ctrl_wght,
                             load_spad_ctrl_iact, pe_start, read_req_psum, out_valid}, '0);
        chk("rst_now_bus", {w_addr_wght, w_addr_iact, w_data_wght, w_data_iact, r_addr_psum, out_data}, '0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        run_pass("after_reset", 0, 0, 0, 0);
        chk("after_reset_cycles", busy_cyc, 522);

        ldw_pre = 1'b1;
        run_pass("pre_load_done", 0, 0, 0, 0);
        chk("pre_spad_w", ctrlw_cyc, 1);
        chk("pre_cycles", busy_cyc, 517);
        ldw_pre = 1'b0;

        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NP; i++) psum_mem[i] = DW'($urandom);
            run_pass("random", 2, 1, 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
